alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Initiator/driver for the alu_16bit datapath block.
- Accepts commands over a valid/ready interface and decodes each opcode into ALU control (ainvert, bnegate, cin, op).
- Sequences single-cycle ops and a 16-iteration shift-add multiply through the ALU adder.
- Captures result/cout/zero and returns them on a valid/ready response channel; sits between the CPU control path and alu_16bit.

Parameters:
- WIDTH, 16, datapath width; must equal the ALU width.
- MUL_ITERS, 16, multiply iterations; must equal WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 NOR, 5 CMP, 6 MUL, 7 reserved.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_result  output  WIDTH  result.
- rsp_cout  output  1  carry flag.
- rsp_zero  output  1  zero flag.
- rsp_err  output  1  illegal or unsupported opcode.
- alu_a  output  WIDTH  ALU operand a.
- alu_b  output  WIDTH  ALU operand b.
- alu_cin  output  1  ALU carry-in.
- alu_ainvert  output  1  ALU a-invert.
- alu_bnegate  output  1  ALU b-negate.
- alu_op  output  3  ALU op select.
- alu_result  input  WIDTH  ALU result (combinational from alu_* outputs).
- alu_cout  input  1  ALU carry-out.
- alu_zero  input  1  ALU zero flag.

Behaviour:
- Reset: state IDLE. cmd_ready=1. rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zero=0, rsp_err=0. All alu_* outputs=0. Reset mid-command aborts it; no response is produced.
- FSM states: IDLE, EXEC, MUL_ITER, RESP.
- IDLE: cmd_ready=1 only in this state. On cmd_valid, latch op/a/b.
  - Op 0-5 -> EXEC.
  - Op 6 -> MUL_ITER with acc=0, mcand=a, mplier=b, cnt=0, sticky=0.
  - Op 7 -> RESP with rsp_err=1, result=0, cout=0, zero=0.
- ALU control decode (alu_* outputs driven from registered state, held stable for the whole state):
  - AND: op=000, ainvert=0, bnegate=0, cin=0.
  - OR: op=010.
  - ADD: op=001, cin=0.
  - SUB and CMP: op=001, bnegate=1, cin=1.
  - NOR: op=000, ainvert=1, bnegate=1.
  - MUL iterations use ADD.
  - In IDLE/RESP all alu_* outputs=0.
- EXEC (1 cycle): at the edge, capture rsp_result=alu_result, rsp_cout=alu_cout, rsp_zero=alu_zero, rsp_err=0 -> RESP.
  - CMP only: rsp_result forced to 0; flags kept (zero = equal, cout=1 means a>=b unsigned).
- MUL_ITER: alu_a=acc, alu_b=mcand. Each edge:
  - If mplier[0]: acc<=alu_result, sticky|=alu_cout.
  - mcand<<=1 (bits shifted out of mcand while mplier is still nonzero also set sticky).
  - mplier>>=1, cnt++.
  - After MUL_ITERS iterations -> RESP with result=acc (low 16 bits of product), cout=sticky (unsigned overflow), zero=(acc==0).
  - Fixed latency; no early exit.
- Latency from the accept edge to rsp_valid high: 2 edges for op 0-5, 1 edge for op 7, MUL_ITERS+1 = 17 edges for MUL.
- RESP: rsp_valid=1. All rsp_* outputs are held stable while rsp_ready=0. On rsp_ready -> IDLE, rsp_valid=0. Next command can be accepted on the following edge.
- No overlap: at most one command in flight. cmd_* inputs are ignored outside IDLE.
- Arithmetic is unsigned modulo 2^16. SUB cout=1 means no borrow.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: op 6 performs the multiply described above.
- Undefined: the MUL_ITER state and multiply registers are not built; op 6 is treated like op 7 (rsp_err=1, latency 1 edge).

Test Plan:
- ADD a=0x000F, b=0x000E -> result=0x001D, cout=0, zero=0, rsp_valid 2 edges after accept; during EXEC alu_op=001, alu_cin=0, alu_bnegate=0.
- SUB 15-14 -> result=0x0001, cout=1. SUB a=1001, b=12341 -> result=0xD3B4, cout=0. CMP a=b=0x1234 -> result=0x0000, zero=1, cout=1.
- AND 0x0001&0x0000 -> 0x0000, zero=1. OR 0x0001|0x0000 -> 0x0001. NOR 0x00FF,0x0F00 -> 0xF000 with alu_ainvert=alu_bnegate=1.
- MUL 300*300 (ALU_SEQ_MUL_EN defined) -> result=0x5F90, cout=1, rsp_valid 17 edges after accept. MUL 0*0xFFFF -> 0x0000, zero=1, cout=0. Macro undefined -> rsp_err=1 after 1 edge.
- Hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_* stable and cmd_ready=0 throughout; a new cmd_valid presented meanwhile is not accepted until after the handshake. Op 7 -> rsp_err=1, result=0.
- Assert reset at iteration 5 of a MUL -> next cycle IDLE, rsp_valid=0, alu_* outputs=0, cmd_ready=1; a following ADD 2+3 returns 0x0005.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer driving an external alu_16bit: decodes opcodes, runs single-cycle ops and an
// optional shift-add multiply (enabled by defining ALU_SEQ_MUL_EN), and returns a response.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MUL_ITERS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero
);

  if (MUL_ITERS != WIDTH) begin : g_cfg_check
    $error("alu_cmd_sequencer: MUL_ITERS must equal WIDTH");
  end

  localparam logic [2:0] OpAnd = 3'd0;
  localparam logic [2:0] OpOr  = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpSub = 3'd3;
  localparam logic [2:0] OpNor = 3'd4;
  localparam logic [2:0] OpCmp = 3'd5;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OpMul = 3'd6;
  localparam int unsigned CntW = $clog2(MUL_ITERS + 1);
`endif

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b010;
  localparam logic [2:0] AluAdd = 3'b001;

  typedef enum logic [1:0] {StIdle, StExec, StMulIter, StResp} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      sticky_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      sticky_q     <= sticky_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    sticky_d     = sticky_q;
`endif
    cmd_ready    = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_cin      = 1'b0;
    alu_ainvert  = 1'b0;
    alu_bnegate  = 1'b0;
    alu_op       = AluAnd;

    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d      = cmd_op;
          a_d       = cmd_a;
          b_d       = cmd_b;
          rsp_err_d = 1'b0;
          case (cmd_op)
            OpAnd, OpOr, OpAdd, OpSub, OpNor, OpCmp: state_d = StExec;
`ifdef ALU_SEQ_MUL_EN
            OpMul: begin
              acc_d    = '0;
              mcand_d  = cmd_a;
              mplier_d = cmd_b;
              cnt_d    = '0;
              sticky_d = 1'b0;
              state_d  = StMulIter;
            end
`endif
            default: begin
              rsp_result_d = '0;
              rsp_cout_d   = 1'b0;
              rsp_zero_d   = 1'b0;
              rsp_err_d    = 1'b1;
              state_d      = StResp;
            end
          endcase
        end
      end

      StExec: begin
        alu_a = a_q;
        alu_b = b_q;
        case (op_q)
          OpOr:  alu_op = AluOr;
          OpAdd: alu_op = AluAdd;
          OpSub, OpCmp: begin
            alu_op      = AluAdd;
            alu_bnegate = 1'b1;
            alu_cin     = 1'b1;
          end
          OpNor: begin
            alu_ainvert = 1'b1;
            alu_bnegate = 1'b1;
          end
          default: alu_op = AluAnd;
        endcase
        // Compare reports only flags: zero means equal, cout means a >= b.
        rsp_result_d = (op_q == OpCmp) ? '0 : alu_result;
        rsp_cout_d   = alu_cout;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = 1'b0;
        state_d      = StResp;
      end

`ifdef ALU_SEQ_MUL_EN
      StMulIter: begin
        alu_a  = acc_q;
        alu_b  = mcand_q;
        alu_op = AluAdd;
        if (mplier_q[0]) begin
          acc_d    = alu_result;
          sticky_d = sticky_d | alu_cout;
        end
        // A dropped multiplicand bit only overflows if a later multiplier bit would add it.
        if (mcand_q[WIDTH-1] && (mplier_q[WIDTH-1:1] != '0)) begin
          sticky_d = 1'b1;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(MUL_ITERS - 1)) begin
          rsp_result_d = acc_d;
          rsp_cout_d   = sticky_d;
          rsp_zero_d   = (acc_d == '0);
          rsp_err_d    = 1'b0;
          state_d      = StResp;
        end
      end
`endif

      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign rsp_valid  = (state_q == StResp);
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural alu_16bit model and a response
// scoreboard; multiply expectations follow ALU_SEQ_MUL_EN.
module tb_alu_cmd_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_cout;
  logic         rsp_zero;
  logic         rsp_err;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_cin;
  logic         alu_ainvert;
  logic         alu_bnegate;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic         alu_zero;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(W), .MUL_ITERS(W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_cout(rsp_cout),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ainvert(alu_ainvert),
    .alu_bnegate(alu_bnegate), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero)
  );

  // alu_16bit model: 000 AND, 010 OR, 001 ADD; carry reported only for the adder.
  logic [W-1:0] aa, bb;
  logic [W:0]   sum;
  always_comb begin
    aa  = alu_ainvert ? ~alu_a : alu_a;
    bb  = alu_bnegate ? ~alu_b : alu_b;
    sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, alu_cin};
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_op)
      3'b000: alu_result = aa & bb;
      3'b010: alu_result = aa | bb;
      3'b001: begin
        alu_result = sum[W-1:0];
        alu_cout   = sum[W];
      end
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   acc_to;
  logic [2:0] ex_op;
  logic       ex_ainv, ex_bneg, ex_cin;

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [31:0] p;
    e.result = '0; e.cout = 1'b0; e.zero = 1'b0; e.err = 1'b0; e.lat = 2;
    p = '0;
    case (op)
      3'd0: e.result = a & b;
      3'd1: e.result = a | b;
      3'd2: {e.cout, e.result} = {1'b0, a} + {1'b0, b};
      3'd3: begin e.result = a - b; e.cout = (a >= b); end
      3'd4: e.result = ~(a | b);
      3'd5: e.cout = (a >= b);
      3'd6: begin
`ifdef ALU_SEQ_MUL_EN
        p = {16'h0, a} * {16'h0, b};
        e.result = p[15:0];
        e.cout   = (p[31:16] != 16'h0);
        e.lat    = W + 1;
`else
        e.err = 1'b1;
        e.lat = 1;
`endif
      end
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    if (!e.err) e.zero = (op == 3'd5) ? (a == b) : (e.result == '0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge with ALU controls sampled.
  task automatic accept_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    sb.push_back(model(op, a, b));
    acc_to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin acc_to = 1'b0; break; end
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    ex_op = alu_op; ex_ainv = alu_ainvert; ex_bneg = alu_bnegate; ex_cin = alu_cin;
  endtask

  // Latency counts edges from the accept edge (inclusive); -1 marks a timeout.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    if (!rsp_valid || acc_to) lat = -1;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL reset_handshake: cmd_ready=%b rsp_valid=%b want 1 0", cmd_ready, rsp_valid);
    else n_pass++;
    n_total++;
    if ({rsp_result, rsp_cout, rsp_zero, rsp_err} !== '0)
      $display("FAIL reset_rsp: result=%h cout=%b zero=%b err=%b want all 0",
               rsp_result, rsp_cout, rsp_zero, rsp_err);
    else n_pass++;
    n_total++;
    if ({alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_op} !== '0)
      $display("FAIL reset_alu: a=%h b=%h cin=%b ainv=%b bneg=%b op=%b want all 0",
               alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_op);
    else n_pass++;
  endtask

  task automatic test_single_cycle();
    logic [2:0]   ops [7] = '{3'd2, 3'd3, 3'd3, 3'd5, 3'd0, 3'd1, 3'd4};
    logic [W-1:0] as  [7] = '{16'h000F, 16'd15, 16'd1001, 16'h1234, 16'h0001, 16'h0001, 16'h00FF};
    logic [W-1:0] bs  [7] = '{16'h000E, 16'd14, 16'd12341, 16'h1234, 16'h0000, 16'h0000, 16'h0F00};
    // {alu_op, ainvert, bnegate, cin} expected while in EXEC
    logic [5:0]   ctl [7] = '{6'b001_000, 6'b001_011, 6'b001_011, 6'b001_011,
                              6'b000_000, 6'b010_000, 6'b000_110};
    exp_t e;
    int lat;
    for (int i = 0; i < 7; i++) begin
      accept_cmd(ops[i], as[i], bs[i]);
      n_total++;
      if ({ex_op, ex_ainv, ex_bneg, ex_cin} !== ctl[i])
        $display("FAIL exec_ctl[%0d]: got %b want %b", i, {ex_op, ex_ainv, ex_bneg, ex_cin}, ctl[i]);
      else n_pass++;
      wait_rsp(lat);
      e = sb.pop_front();
      n_total++;
      if (lat !== e.lat) $display("FAIL latency[%0d]: got %0d want %0d", i, lat, e.lat);
      else n_pass++;
      n_total++;
      if ({rsp_err, rsp_cout, rsp_zero, rsp_result} !== {e.err, e.cout, e.zero, e.result})
        $display("FAIL rsp[%0d]: got err=%b cout=%b zero=%b result=%h want err=%b cout=%b zero=%b result=%h",
                 i, rsp_err, rsp_cout, rsp_zero, rsp_result, e.err, e.cout, e.zero, e.result);
      else n_pass++;
      release_rsp();
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] as [2] = '{16'd300, 16'h0000};
    logic [W-1:0] bs [2] = '{16'd300, 16'hFFFF};
    exp_t e;
    int lat;
    for (int i = 0; i < 2; i++) begin
      accept_cmd(3'd6, as[i], bs[i]);
`ifdef ALU_SEQ_MUL_EN
      n_total++;
      if (ex_op !== 3'b001 || alu_a !== 16'h0000 || alu_b !== as[i])
        $display("FAIL mul_iter_ctl[%0d]: op=%b a=%h b=%h want 001 0000 %h", i, ex_op, alu_a, alu_b, as[i]);
      else n_pass++;
`endif
      wait_rsp(lat);
      e = sb.pop_front();
      n_total++;
      if (lat !== e.lat) $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, e.lat);
      else n_pass++;
      n_total++;
      if ({rsp_err, rsp_cout, rsp_zero, rsp_result} !== {e.err, e.cout, e.zero, e.result})
        $display("FAIL mul_rsp[%0d]: got err=%b cout=%b zero=%b result=%h want err=%b cout=%b zero=%b result=%h",
                 i, rsp_err, rsp_cout, rsp_zero, rsp_result, e.err, e.cout, e.zero, e.result);
      else n_pass++;
      release_rsp();
    end
  endtask

  task automatic test_reserved();
    exp_t e;
    int lat;
    accept_cmd(3'd7, 16'h1234, 16'h5678);
    wait_rsp(lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat) $display("FAIL op7_latency: got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_total++;
    if ({rsp_err, rsp_cout, rsp_zero, rsp_result} !== {e.err, e.cout, e.zero, e.result})
      $display("FAIL op7_rsp: got err=%b cout=%b zero=%b result=%h want err=1 cout=0 zero=0 result=0000",
               rsp_err, rsp_cout, rsp_zero, rsp_result);
    else n_pass++;
    release_rsp();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    accept_cmd(3'd2, 16'h00F0, 16'h0F00);
    wait_rsp(lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat) $display("FAIL bp_latency: got %0d want %0d", lat, e.lat);
    else n_pass++;
    // Offer a second command while the response is stalled.
    cmd_op = 3'd1; cmd_a = 16'h0001; cmd_b = 16'h0000; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({rsp_valid, cmd_ready, rsp_err, rsp_cout, rsp_zero, rsp_result} !==
          {1'b1, 1'b0, e.err, e.cout, e.zero, e.result})
        $display("FAIL bp_hold[%0d]: valid=%b cmd_ready=%b err=%b cout=%b zero=%b result=%h want 1 0 %b %b %b %h",
                 i, rsp_valid, cmd_ready, rsp_err, rsp_cout, rsp_zero, rsp_result,
                 e.err, e.cout, e.zero, e.result);
      else n_pass++;
      if (i < 3) begin @(posedge clk); @(negedge clk); end
    end
    release_rsp();
    n_total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL bp_after_handshake: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
    else n_pass++;
    accept_cmd(3'd1, 16'h0001, 16'h0000);
    wait_rsp(lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat || {rsp_err, rsp_zero, rsp_result} !== {e.err, e.zero, e.result})
      $display("FAIL bp_second: lat=%0d result=%h zero=%b err=%b want lat=%0d result=%h zero=%b err=%b",
               lat, rsp_result, rsp_zero, rsp_err, e.lat, e.result, e.zero, e.err);
    else n_pass++;
    release_rsp();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat;
`ifdef ALU_SEQ_MUL_EN
    accept_cmd(3'd6, 16'd300, 16'd300);
    repeat (5) begin @(posedge clk); @(negedge clk); end
`else
    accept_cmd(3'd2, 16'h0010, 16'h0020);
`endif
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    sb.delete();
    n_total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL abort_state: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
    else n_pass++;
    n_total++;
    if ({alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_op} !== '0)
      $display("FAIL abort_alu: a=%h b=%h cin=%b ainv=%b bneg=%b op=%b want all 0",
               alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_op);
    else n_pass++;
    repeat (20) begin @(posedge clk); @(negedge clk); end
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL abort_no_rsp: rsp_valid=%b want 0", rsp_valid);
    else n_pass++;
    accept_cmd(3'd2, 16'd2, 16'd3);
    wait_rsp(lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat || {rsp_err, rsp_cout, rsp_zero, rsp_result} !== {e.err, e.cout, e.zero, e.result})
      $display("FAIL abort_then_add: lat=%0d result=%h cout=%b zero=%b want lat=%0d result=%h cout=%b zero=%b",
               lat, rsp_result, rsp_cout, rsp_zero, e.lat, e.result, e.cout, e.zero);
    else n_pass++;
    release_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    acc_to = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
